ddr_wr_burst_coalescer: RTL and testbench

Write-side DDR adapter placed between the store queue's DDR port (`stq_ddr_valid/ready/addr/data`) and the Avalon-MM write master `m_wchannel0`. It buffers store beats and merges runs of address-contiguous beats into Avalon bursts of up to MAX_BURST beats. It honours `waitrequest` with correct Avalon semantics and reports when all writes have drained, so the SpMV sequencer can gate `done`.

---
 rtl/wr_coalesce_pkg.sv | 26 ++
 rtl/wr_coalesce_fifo.sv | 44 ++++
 rtl/ddr_wr_burst_coalescer.sv | 208 ++++++++++++++++++++
 tb/tb_ddr_wr_burst_coalescer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wr_coalesce_pkg.sv
// Shared types and constants for the DDR write-burst coalescer.
package wr_coalesce_pkg;

   localparam int PKG_DATA_WIDTH = 512;
   localparam int PKG_ADDR_WIDTH = 32;
   localparam int STRIDE         = PKG_DATA_WIDTH / 8;
   localparam int STRIDE_SHIFT   = $clog2(STRIDE);
   localparam int BC_WIDTH       = 7;

   // Burst descriptor at the default address width: start address and beat count.
   typedef struct packed {
      logic [PKG_ADDR_WIDTH-1:0] addr;
      logic [BC_WIDTH-1:0]       len;
   } desc_t;

   typedef enum logic {
      S_IDLE,
      S_BURST
   } state_t;

   // Byte-offset shift of one data beat for an arbitrary beat width.
   function automatic int stride_shift(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/wr_coalesce_fifo.sv
// Synchronous FIFO with show-ahead head output. Pointers carry an extra
// wrap bit so full and empty are told apart without a counter.
// DEPTH must be a power of two, at least 2.
module wr_coalesce_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // storage array; left unreset so it can map onto RAM
   always_ff @(posedge clock) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end

   // read/write pointers, modulo DEPTH plus wrap bit
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/ddr_wr_burst_coalescer.sv
// Store-queue to Avalon-MM write adapter. Address-contiguous store beats are
// merged into bursts of up to MAX_BURST beats; idle reports a full drain.
// Optional statistics counters are enabled with WR_COALESCE_STATS_EN.
//
// state   | meaning
// S_IDLE  | no burst in flight; pops the next descriptor when one is queued
// S_BURST | m_write high, streaming data FIFO beats until the count is done
module ddr_wr_burst_coalescer
   import wr_coalesce_pkg::*;
#(
   parameter int DDR_DATA_WIDTH = 512,
   parameter int ADDR_WIDTH     = 32,
   parameter int MAX_BURST      = 16,
   parameter int FIFO_DEPTH     = 64,
   parameter int FLUSH_TIMEOUT  = 32
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [ADDR_WIDTH-1:0]       in_addr,
   input  logic [DDR_DATA_WIDTH-1:0]   in_data,
   output logic [ADDR_WIDTH-1:0]       m_address,
   output logic                        m_write,
   output logic [DDR_DATA_WIDTH-1:0]   m_writedata,
   output logic [DDR_DATA_WIDTH/8-1:0] m_be,
   output logic [6:0]                  m_burstcount,
   output logic                        m_read,
   input  logic                        m_waitrequest,
   output logic                        idle
`ifdef WR_COALESCE_STATS_EN
   ,
   output logic [31:0]                 stat_bursts,
   output logic [31:0]                 stat_beats
`endif
);

   localparam int BEAT_BYTES = 1 << stride_shift(DDR_DATA_WIDTH);
   localparam int TW         = $clog2(FLUSH_TIMEOUT) + 1;
   localparam int DW         = ADDR_WIDTH + BC_WIDTH;
   localparam logic [BC_WIDTH-1:0] MAX_LEN  = BC_WIDTH'(MAX_BURST);
   localparam logic [TW-1:0]       TMO_LAST = TW'(FLUSH_TIMEOUT - 1);

   logic                  accept;
   logic                  data_full, data_empty, data_pop;
   logic                  desc_full, desc_empty, desc_pop, desc_push;
   logic [DW-1:0]         desc_in, desc_head;
   logic [DDR_DATA_WIDTH-1:0] data_head;

   logic [ADDR_WIDTH-1:0] run_base, next_addr, addr_al;
   logic                  next_wrap;
   logic [BC_WIDTH-1:0]   run_len, beats_left;
   logic [TW-1:0]         tmo_cnt;
   logic [ADDR_WIDTH:0]   addr_inc;
   logic                  run_open, contig, extend, close_now;

   state_t                state;

   assign in_ready = !reset && !data_full && !desc_full;
   assign accept   = in_valid && in_ready;

   assign addr_al  = in_addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
   assign addr_inc = {1'b0, addr_al} + (ADDR_WIDTH + 1)'(BEAT_BYTES);
   assign run_open = (run_len != '0);
   // a run that reached the top of the address space cannot be extended
   assign contig   = !next_wrap && (addr_al == next_addr);
   assign extend   = run_open && contig;
   assign close_now = run_open && !accept && (flush || tmo_cnt == TMO_LAST) && !desc_full;

   // descriptor push: at most one per cycle, always in the same cycle as (or
   // after) the final beat of the run is written to the data FIFO
   always_comb begin
      desc_push = 1'b0;
      desc_in   = {run_base, run_len};
      if (accept) begin
         if (run_open && !contig) begin
            desc_push = 1'b1;
         end else if (extend && (run_len + 7'd1 == MAX_LEN)) begin
            desc_push = 1'b1;
            desc_in   = {run_base, run_len + 7'd1};
         end else if (!run_open && MAX_LEN == 7'd1) begin
            desc_push = 1'b1;
            desc_in   = {addr_al, 7'd1};
         end
      end else if (close_now) begin
         desc_push = 1'b1;
      end
   end

   // run tracker: start, extend, or close the currently open run
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         run_base  <= '0;
         next_addr <= '0;
         next_wrap <= 1'b0;
         run_len   <= '0;
         tmo_cnt   <= '0;
      end else if (accept) begin
         tmo_cnt   <= '0;
         next_addr <= addr_inc[ADDR_WIDTH-1:0];
         next_wrap <= addr_inc[ADDR_WIDTH];
         if (extend) begin
            run_len <= (run_len + 7'd1 == MAX_LEN) ? '0 : run_len + 7'd1;
         end else begin
            run_base <= addr_al;
            run_len  <= (MAX_LEN == 7'd1) ? '0 : 7'd1;
         end
      end else if (run_open) begin
         if (close_now) begin
            run_len <= '0;
            tmo_cnt <= '0;
         end else if (tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end
   end

   wr_coalesce_fifo #(
      .WIDTH (DDR_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_data_fifo (
      .clock (clock),
      .reset (reset),
      .push  (accept),
      .din   (in_data),
      .pop   (data_pop),
      .head  (data_head),
      .full  (data_full),
      .empty (data_empty)
   );

   wr_coalesce_fifo #(
      .WIDTH (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_desc_fifo (
      .clock (clock),
      .reset (reset),
      .push  (desc_push),
      .din   (desc_in),
      .pop   (desc_pop),
      .head  (desc_head),
      .full  (desc_full),
      .empty (desc_empty)
   );

   assign desc_pop = (state == S_IDLE) && !desc_empty;
   assign data_pop = m_write && !m_waitrequest;

   // output FSM; address and burstcount only change when a descriptor is loaded
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         m_write      <= 1'b0;
         m_address    <= '0;
         m_burstcount <= '0;
         beats_left   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!desc_empty) begin
                  m_address    <= desc_head[DW-1:BC_WIDTH];
                  m_burstcount <= desc_head[BC_WIDTH-1:0];
                  beats_left   <= desc_head[BC_WIDTH-1:0];
                  m_write      <= 1'b1;
                  state        <= S_BURST;
               end
            end
            S_BURST: begin
               if (!m_waitrequest) begin
                  if (beats_left == 7'd1) begin
                     m_write <= 1'b0;
                     state   <= S_IDLE;
                  end else begin
                     beats_left <= beats_left - 7'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // a burst never outruns the beats its descriptor accounted for
   always @(posedge clock) begin
      if (!reset) assert (!(data_pop && data_empty));
   end

   // head is stable while stalled since the data FIFO only pops on acceptance
   assign m_writedata = m_write ? data_head : '0;
   assign m_be        = '1;
   assign m_read      = 1'b0;
   assign idle        = !run_open && desc_empty && data_empty && (state == S_IDLE);

`ifdef WR_COALESCE_STATS_EN
   // saturating counters of completed bursts and accepted Avalon beats
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_bursts <= '0;
         stat_beats  <= '0;
      end else if (data_pop) begin
         if (stat_beats != '1) stat_beats <= stat_beats + 32'd1;
         if (beats_left == 7'd1 && stat_bursts != '1) stat_bursts <= stat_bursts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ddr_wr_burst_coalescer.sv
// Directed bench for ddr_wr_burst_coalescer at default parameters.
module tb_ddr_wr_burst_coalescer;

   localparam int FT = 32;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  in_addr = '0;
   logic [511:0] in_data = '0;
   logic [31:0]  m_address;
   logic         m_write;
   logic [511:0] m_writedata;
   logic [63:0]  m_be;
   logic [6:0]   m_burstcount;
   logic         m_read;
   logic         m_waitrequest = 1'b0;
   logic         idle;
`ifdef WR_COALESCE_STATS_EN
   logic [31:0]  stat_bursts, stat_beats;
`endif

   ddr_wr_burst_coalescer dut (
      .clock         (clock),
      .reset         (reset),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_addr       (in_addr),
      .in_data       (in_data),
      .m_address     (m_address),
      .m_write       (m_write),
      .m_writedata   (m_writedata),
      .m_be          (m_be),
      .m_burstcount  (m_burstcount),
      .m_read        (m_read),
      .m_waitrequest (m_waitrequest),
      .idle          (idle)
`ifdef WR_COALESCE_STATS_EN
      ,
      .stat_bursts   (stat_bursts),
      .stat_beats    (stat_beats)
`endif
   );

   always #5 clock = ~clock;

   int total = 0;
   int passed = 0;
   int cyc = 0;
   int n_acc = 0;
   int last_acc = 0;
   logic prev_write = 1'b0;
   logic [31:0]  q_addr[$];
   logic [6:0]   q_bc[$];
   logic [511:0] q_data[$];
   int           q_start[$];

   always @(posedge clock) cyc++;

   // record every accepted upstream beat and every accepted Avalon beat
   always @(negedge clock) begin
      if (reset) begin
         prev_write = 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            n_acc++;
            last_acc = cyc;
         end
         if (m_write && !m_waitrequest) begin
            q_addr.push_back(m_address);
            q_bc.push_back(m_burstcount);
            q_data.push_back(m_writedata);
         end
         if (m_write && !prev_write) q_start.push_back(cyc);
         prev_write = m_write;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [511:0] dv(input int k);
      return {16{k}};
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic clear_q();
      q_addr.delete();
      q_bc.delete();
      q_data.delete();
      q_start.delete();
   endtask

   // called just after a rising edge; returns just after the accepting edge
   task automatic send(input logic [31:0] a, input logic [511:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      @(negedge clock);
      while (!in_ready && n < 500) begin
         @(negedge clock);
         n++;
      end
      chk("send_ready", in_ready, 1);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clock);
      while (!(idle && !m_write) && n < budget) begin
         @(negedge clock);
         n++;
      end
      chk("idle_reached", idle, 1);
      @(posedge clock);
      #1;
   endtask

   task automatic chk_beat(input string tag, input int i, input logic [31:0] a,
                           input logic [6:0] bc, input logic [511:0] d);
      chk({tag, "_addr"}, (i < q_addr.size()) ? q_addr[i] : 32'hx, a);
      chk({tag, "_bc"},   (i < q_bc.size())   ? q_bc[i]   : 7'hx,  bc);
      chk({tag, "_data"}, (i < q_data.size()) ? q_data[i] : 'x,    d);
   endtask

   int n0, f;
   logic pw, pwr;
   logic [31:0]  pa;
   logic [6:0]   pb;
   logic [511:0] pd;

   initial begin
      // reset values
      #12;
      chk("rst_write", m_write, 0);
      chk("rst_address", m_address, 0);
      chk("rst_burstcount", m_burstcount, 0);
      chk("rst_writedata", m_writedata, 0);
      chk("rst_idle", idle, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_be", m_be, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("rst_read", m_read, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("post_rst_in_ready", in_ready, 1);
      @(posedge clock);
      #1;

      // 16 contiguous beats -> one full burst two cycles after the last accept
      clear_q();
      for (int i = 0; i < 16; i++) send(32'h1000 + 32'(i * 64), dv(32'h100 + i));
      wait_idle(200);
      chk("t1_beats", q_addr.size(), 16);
      for (int i = 0; i < 16; i++) chk_beat("t1", i, 32'h1000, 7'd16, dv(32'h100 + i));
      chk("t1_latency", (q_start.size() > 0) ? q_start[0] - last_acc : -1, 2);

      // 20 contiguous beats -> 16 + 4, tail closed by timeout
      clear_q();
      for (int i = 0; i < 20; i++) send(32'h2000 + 32'(i * 64), dv(32'h200 + i));
      wait_idle(200);
      chk("t2_beats", q_addr.size(), 20);
      for (int i = 0; i < 20; i++)
         chk_beat("t2", i, (i < 16) ? 32'h2000 : 32'h2400, (i < 16) ? 7'd16 : 7'd4, dv(32'h200 + i));
      chk("t2_bursts", q_start.size(), 2);
      chk("t2_timeout", (q_start.size() > 1) ? q_start[1] - last_acc : -1, FT + 2);

      // address gap splits into two bursts of 2
      clear_q();
      send(32'h0000, dv(32'h31));
      send(32'h0040, dv(32'h32));
      send(32'h0200, dv(32'h33));
      send(32'h0240, dv(32'h34));
      wait_idle(200);
      chk("t3_beats", q_addr.size(), 4);
      chk_beat("t3", 0, 32'h0000, 7'd2, dv(32'h31));
      chk_beat("t3", 1, 32'h0000, 7'd2, dv(32'h32));
      chk_beat("t3", 2, 32'h0200, 7'd2, dv(32'h33));
      chk_beat("t3", 3, 32'h0200, 7'd2, dv(32'h34));

      // waitrequest toggling every cycle during an 8-beat burst
      clear_q();
      for (int i = 0; i < 8; i++) send(32'h3000 + 32'(i * 64), dv(32'h300 + i));
      pw = 1'b0;
      pwr = 1'b0;
      pa = '0;
      pb = '0;
      pd = '0;
      for (int i = 0; i < 40; i++) begin
         flush = (i == 0);
         m_waitrequest = ((i % 2) == 0);
         @(negedge clock);
         if (m_write) begin
            chk("t4_addr_const", m_address, 32'h3000);
            chk("t4_bc_const", m_burstcount, 7'd8);
         end
         if (pw && pwr) begin
            chk("t4_stall_addr", m_address, pa);
            chk("t4_stall_bc", m_burstcount, pb);
            chk("t4_stall_data", m_writedata, pd);
         end
         pw  = m_write;
         pwr = m_waitrequest;
         pa  = m_address;
         pb  = m_burstcount;
         pd  = m_writedata;
         @(posedge clock);
         #1;
      end
      flush = 1'b0;
      m_waitrequest = 1'b0;
      wait_idle(200);
      chk("t4_beats", q_addr.size(), 8);
      for (int i = 0; i < 8; i++) chk_beat("t4", i, 32'h3000, 7'd8, dv(32'h300 + i));

      // FIFO full under sustained waitrequest, then drain
      clear_q();
      m_waitrequest = 1'b1;
      n0 = n_acc;
      for (int i = 0; i < 64; i++) send(32'h8000 + 32'(i * 64), dv(32'h500 + i));
      in_valid = 1'b1;
      in_addr  = 32'h9000;
      in_data  = dv(32'h540);
      repeat (5) @(negedge clock);
      chk("t5_full_ready", in_ready, 0);
      chk("t5_held_accepts", n_acc - n0, 64);
      @(posedge clock);
      #1;
      m_waitrequest = 1'b0;
      send(32'h9000, dv(32'h540));
      wait_idle(400);
      chk("t5_ready_back", in_ready, 1);
      chk("t5_beats", q_addr.size(), 65);
      for (int i = 0; i < 64; i++)
         chk_beat("t5", i, 32'h8000 + 32'((i / 16) * 32'h400), 7'd16, dv(32'h500 + i));
      chk_beat("t5_tail", 64, 32'h9000, 7'd1, dv(32'h540));

      // flush closes a 3-beat run; reset mid-burst clears everything at once
      clear_q();
      for (int i = 0; i < 3; i++) send(32'hA000 + 32'(i * 64), dv(32'h600 + i));
      m_waitrequest = 1'b1;
      flush = 1'b1;
      @(negedge clock);
      f = cyc;
      @(posedge clock);
      #1;
      flush = 1'b0;
      @(negedge clock);
      chk("t6_write_f1", m_write, 0);
      @(negedge clock);
      chk("t6_cycles", cyc - f, 2);
      chk("t6_write_f2", m_write, 1);
      chk("t6_bc", m_burstcount, 7'd3);
      chk("t6_addr", m_address, 32'hA000);
      chk("t6_data", m_writedata, dv(32'h600));
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_write", m_write, 0);
      chk("t6_rst_idle", idle, 1);
      chk("t6_rst_ready", in_ready, 0);
      chk("t6_rst_addr", m_address, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      m_waitrequest = 1'b0;
      repeat (5) @(negedge clock);
      chk("t6_post_idle", idle, 1);
      chk("t6_post_write", m_write, 0);
      chk("t6_no_beats", q_addr.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
